blake2_job_ctrl: RTL and testbench

//  Host-side sequencer for the BLAKE2s core on the Pmod byte bus. Takes one hash job (kk, nn, ll)

---
 rtl/blake2_job_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_blake2_job_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_job_ctrl.sv
// blake2_job_ctrl
//   Host-side job sequencer for the BLAKE2s core on the Pmod byte bus.
//   Accepts one job (kk, nn, ll) and emits a config header and then 64-byte
//   blocks to the core. Key and message bytes come from the requester stream,
//   and zero padding is inserted to fill each block. It then collects nn hash
//   bytes from the core and forwards them to the requester.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start_i, kk_i, nn_i, ll_i  job request (taken in IDLE only)
//   busy_o                     job in flight
//   msg_valid_i/msg_data_i/msg_ready_o  requester key+message byte stream
//   data_o, data_ctrl_o        byte to core, {cmd[1:0], valid}
//   hash_ctrl_i, hash_i        [0] core ready, [1] hash byte valid; hash byte
//   res_valid_o/res_data_o/res_last_o   hash bytes back to requester
//   done_o, err_o, err_code_o  job completion / abort (1 cfg, 2 timeout, 3 stray hash)
module blake2_job_ctrl #(
  parameter int LL_W      = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [5:0]      kk_i,
  input  logic [5:0]      nn_i,
  input  logic [LL_W-1:0] ll_i,
  output logic            busy_o,
  input  logic            msg_valid_i,
  input  logic [7:0]      msg_data_i,
  output logic            msg_ready_o,
  output logic [7:0]      data_o,
  output logic [2:0]      data_ctrl_o,
  input  logic [1:0]      hash_ctrl_i,
  input  logic [7:0]      hash_i,
  output logic            res_valid_o,
  output logic [7:0]      res_data_o,
  output logic            res_last_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o
);
  // Byte positions need one bit more than ll so ll = 2^LL_W-1 plus a key
  // block and padding never wraps.
  localparam int PW    = LL_W + 1;
  localparam int HDR_N = LL_W/8 + 2;
  localparam int HW    = LL_W + 16;
  localparam logic [7:0] HDR_LAST = 8'(HDR_N - 1);
  // Error is raised on the edge where the watchdog reaches all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_EXP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_BLK, S_WAIT, S_READ} state_t;
  state_t r_state, w_state_nxt;

  logic [HW-1:0]        r_hdr;
  logic [7:0]           r_hidx;
  logic [5:0]           r_nn, r_kk, r_hcnt;
  logic [PW-1:0]        r_pos, r_kbase, r_msg_end, r_total, r_last_blk;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_vld;
  logic [1:0]           r_cmd;
  logic [7:0]           r_data;
  logic                 r_res_valid, r_res_last, r_done, r_err;
  logic [7:0]           r_res_data;
  logic [1:0]           r_err_code;

  logic          w_load, w_hv, w_bad, w_blk_end, w_due, w_hlast, w_wd_exp;
  logic [PW-1:0] w_kbase, w_rup, w_sum, w_total;
  logic [1:0]    w_cmd;

  // Output register may load when empty or when the core takes its byte.
  assign w_load    = ~r_vld | hash_ctrl_i[0];
  assign w_hv      = hash_ctrl_i[1];
  assign w_bad     = (nn_i == 6'd0) || (nn_i > 6'd32) || (kk_i > 6'd32);
  assign w_blk_end = (r_pos == r_total);
  // Stream bytes: key at [0,kk), message at [kbase, kbase+ll); rest is padding.
  assign w_due     = (r_pos < PW'(r_kk)) || ((r_pos >= r_kbase) && (r_pos < r_msg_end));
  assign w_cmd     = (r_pos >= r_last_blk) ? 2'b10 : 2'b01;
  assign w_hlast   = ((r_hcnt + 6'd1) == r_nn);
  assign w_wd_exp  = (r_wd == WD_EXP);
  assign w_kbase   = (kk_i != 6'd0) ? PW'(64) : '0;
  assign w_rup     = (PW'(ll_i) + PW'(63)) & ~PW'(63);
  assign w_sum     = w_kbase + w_rup;
  assign w_total   = (w_sum == '0) ? PW'(64) : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i && !w_bad) w_state_nxt = S_CFG;
      S_CFG: begin
        if (w_hv) w_state_nxt = S_IDLE;
        else if (w_load && (r_hidx == HDR_LAST)) w_state_nxt = S_BLK;
      end
      S_BLK: begin
        if (w_hv) w_state_nxt = S_IDLE;
        else if (w_load && w_blk_end) w_state_nxt = S_WAIT;
      end
      S_WAIT, S_READ: begin
        if (w_hv) w_state_nxt = w_hlast ? S_IDLE : S_READ;
        else if (w_wd_exp) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (r_state != S_IDLE);
    msg_ready_o = (r_state == S_BLK) && !w_hv && !w_blk_end && w_due && w_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr <= '0; r_hidx <= '0; r_kk <= '0; r_nn <= '0; r_hcnt <= '0;
      r_pos <= '0; r_kbase <= '0; r_msg_end <= '0; r_total <= '0; r_last_blk <= '0;
      r_wd <= '0; r_vld <= 1'b0; r_cmd <= '0; r_data <= '0;
      r_res_valid <= 1'b0; r_res_last <= 1'b0; r_res_data <= '0;
      r_done <= 1'b0; r_err <= 1'b0; r_err_code <= '0;
    end else begin
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_kk <= kk_i;
            r_nn <= nn_i;
            if (w_bad) begin
              r_err <= 1'b1; r_err_code <= 2'd1;
            end else begin
              // kk goes out now; the rest of the header is shifted out of r_hdr.
              r_data     <= {2'b00, kk_i};
              r_cmd      <= 2'b00;
              r_vld      <= 1'b1;
              r_hdr      <= {8'h00, ll_i, 2'b00, nn_i};
              r_hidx     <= 8'd1;
              r_pos      <= '0;
              r_kbase    <= w_kbase;
              r_msg_end  <= w_kbase + PW'(ll_i);
              r_total    <= w_total;
              r_last_blk <= w_total - PW'(64);
              r_hcnt     <= '0;
              r_wd       <= '0;
            end
          end
        end
        S_CFG: begin
          if (w_hv) begin
            r_vld <= 1'b0; r_err <= 1'b1; r_err_code <= 2'd3;
          end else if (w_load) begin
            r_data <= r_hdr[7:0];
            r_hdr  <= r_hdr >> 8;
            r_hidx <= r_hidx + 8'd1;
            r_vld  <= 1'b1;
          end
        end
        S_BLK: begin
          if (w_hv) begin
            r_vld <= 1'b0; r_err <= 1'b1; r_err_code <= 2'd3;
          end else if (w_load) begin
            if (w_blk_end) begin
              r_vld <= 1'b0;
              r_wd  <= '0;
            end else if (!w_due) begin
              r_data <= 8'h00; r_cmd <= w_cmd; r_vld <= 1'b1; r_pos <= r_pos + PW'(1);
            end else if (msg_valid_i) begin
              r_data <= msg_data_i; r_cmd <= w_cmd; r_vld <= 1'b1; r_pos <= r_pos + PW'(1);
            end else begin
              r_vld <= 1'b0;
            end
          end
        end
        S_WAIT, S_READ: begin
          if (w_hv) begin
            r_res_valid <= 1'b1;
            r_res_data  <= hash_i;
            r_hcnt      <= r_hcnt + 6'd1;
            r_wd        <= '0;
            if (w_hlast) begin
              r_res_last <= 1'b1; r_done <= 1'b1;
            end
          end else if (w_wd_exp) begin
            r_wd <= r_wd + 1'b1; r_err <= 1'b1; r_err_code <= 2'd2;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o      = r_data;
  assign data_ctrl_o = {r_cmd, r_vld};
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_last_o  = r_res_last;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;
endmodule

// File: tb/tb_blake2_job_ctrl.sv
// Bench for blake2_job_ctrl: a job-level model builds the expected core byte
// stream (header, key block, message blocks, padding, cmd codes) and a compare
// process checks every core handshake, stall stability and hash forwarding.
module tb_blake2_job_ctrl;
  localparam int LL_W = 32;
  localparam int TW   = 8;

  logic            clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [5:0]      kk_i = '0, nn_i = '0;
  logic [LL_W-1:0] ll_i = '0;
  logic            busy_o, msg_ready_o, msg_valid_i = 1'b0;
  logic [7:0]      msg_data_i = '0, data_o, hash_i = '0, res_data_o;
  logic [2:0]      data_ctrl_o;
  logic [1:0]      hash_ctrl_i = 2'b00, err_code_o;
  logic            res_valid_o, res_last_o, done_o, err_o;

  blake2_job_ctrl #(.LL_W(LL_W), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .busy_o(busy_o), .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i),
    .msg_ready_o(msg_ready_o), .data_o(data_o), .data_ctrl_o(data_ctrl_o),
    .hash_ctrl_i(hash_ctrl_i), .hash_i(hash_i), .res_valid_o(res_valid_o),
    .res_data_o(res_data_o), .res_last_o(res_last_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sbyte(int i);
    return 8'(i * 37 + 11);
  endfunction
  function automatic logic [7:0] hval(int i);
    return 8'(165 ^ (i * 13));
  endfunction

  // ---------------- job-level model ----------------
  logic [9:0] exp_q[$];

  task automatic build_model(input int kk, input int nn, input int ll);
    logic [7:0]      body[$];
    logic [LL_W-1:0] l;
    l = LL_W'(ll);
    exp_q.delete();
    exp_q.push_back({2'b00, 8'(kk)});
    exp_q.push_back({2'b00, 8'(nn)});
    for (int b = 0; b < LL_W/8; b++) exp_q.push_back({2'b00, 8'(l >> (8*b))});
    if (kk > 0) for (int i = 0; i < 64; i++) body.push_back((i < kk) ? sbyte(i) : 8'h00);
    for (int i = 0; i < (ll + 63) / 64 * 64; i++) body.push_back((i < ll) ? sbyte(kk + i) : 8'h00);
    if (body.size() == 0) repeat (64) body.push_back(8'h00);
    for (int i = 0; i < body.size(); i++)
      exp_q.push_back({((i >= body.size() - 64) ? 2'b10 : 2'b01), body[i]});
  endtask

  // ---------------- compare process ----------------
  logic       chk_on = 1'b0, prev_hv = 1'b0, stall_pend = 1'b0;
  logic [10:0] held = '0;
  int cur_nn = 0, n_core = 0, n_cmd1 = 0, n_hs = 0, n_rdy = 0, res_cnt = 0, n_done = 0;
  logic [7:0] log_b [0:7];

  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    if (chk_on) begin
      if (stall_pend) chk("hold_stable", {data_ctrl_o, data_o}, held);
      stall_pend = data_ctrl_o[0] && !hash_ctrl_i[0];
      held = {data_ctrl_o, data_o};
      if (data_ctrl_o[0] && hash_ctrl_i[0]) begin
        if (exp_q.size() == 0) chk("extra_core_byte", {data_ctrl_o, data_o}, 11'h0);
        else begin
          e = exp_q.pop_front();
          chk("core_byte", {data_ctrl_o[2:1], data_o}, e);
        end
        if (n_core < 8) log_b[n_core] = data_o;
        n_core++;
        if (data_ctrl_o[2:1] == 2'b01) n_cmd1++;
      end
      if (msg_ready_o) n_rdy++;
      if (msg_ready_o && msg_valid_i) n_hs++;
      chk("res_valid", res_valid_o, prev_hv);
      if (res_valid_o) begin
        res_cnt++;
        chk("res_data", res_data_o, hval(res_cnt - 1));
        chk("res_last", res_last_o, res_cnt == cur_nn);
        chk("done_with_last", done_o, res_cnt == cur_nn);
      end else chk("done_quiet", done_o, 0);
      if (done_o) n_done++;
      chk("err_quiet", err_o, 0);
      prev_hv = hash_ctrl_i[1];
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_job(input int kk, input int nn, input int ll, input bit stall);
    int idx, cyc;
    bit hs;
    idx = 0; cyc = 0;
    build_model(kk, nn, ll);
    cur_nn = nn; n_core = 0; n_cmd1 = 0; n_hs = 0; n_rdy = 0; res_cnt = 0; n_done = 0;
    prev_hv = 1'b0; stall_pend = 1'b0; chk_on = 1'b1;
    hash_ctrl_i = 2'b01;
    start_i = 1'b1; kk_i = 6'(kk); nn_i = 6'(nn); ll_i = LL_W'(ll);
    step();
    start_i = 1'b0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      msg_valid_i    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_data_i     = (idx < kk + ll) ? sbyte(idx) : 8'hEE;
      hash_ctrl_i[0] = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      hs = msg_valid_i && msg_ready_o;
      step();
      if (hs) idx++;
      cyc++;
    end
    chk("blk_phase_left", exp_q.size(), 0);
    msg_valid_i = 1'b0;
    hash_ctrl_i[0] = 1'b1;
  endtask

  task automatic finish_hash(input int kk, input int ll, input int nn);
    for (int i = 0; i < nn; i++) begin
      hash_ctrl_i[1] = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      hash_i = hval(i);
      hash_ctrl_i[1] = 1'b1;
      step();
    end
    hash_ctrl_i[1] = 1'b0;
    repeat (3) step();
    chk("res_count", res_cnt, nn);
    chk("done_count", n_done, 1);
    chk("msg_handshakes", n_hs, kk + ll);
    chk("busy_after_done", busy_o, 0);
    chk_on = 1'b0;
  endtask

  task automatic bad_cfg(input int kk, input int nn);
    chk_on = 1'b0;
    start_i = 1'b1; kk_i = 6'(kk); nn_i = 6'(nn); ll_i = LL_W'(5);
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("cfg_err", err_o, 1);
    chk("cfg_err_code", err_code_o, 1);
    chk("cfg_busy", busy_o, 0);
    chk("cfg_no_send", data_ctrl_o[0], 0);
    @(negedge clk);
    chk("cfg_err_pulse", err_o, 0);
    chk("cfg_still_idle", {busy_o, data_ctrl_o[0]}, 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit got;
    #3;
    chk("rst_busy", busy_o, 0);
    chk("rst_ctrl", {data_ctrl_o, data_o}, 0);
    chk("rst_res", {res_valid_o, res_data_o, res_last_o}, 0);
    chk("rst_flags", {done_o, err_o, err_code_o, msg_ready_o}, 0);
    #9 rst_n = 1'b1;
    step();

    // 1: empty job, 32-byte hash
    send_job(0, 32, 0, 0);
    finish_hash(0, 0, 32);
    chk("t1_cfg0", log_b[0], 8'h00);
    chk("t1_cfg1", log_b[1], 8'h20);
    chk("t1_cfg2", log_b[2], 8'h00);
    chk("t1_cfg5", log_b[5], 8'h00);
    chk("t1_bytes", n_core, 70);
    chk("t1_ready_never", n_rdy, 0);

    // 2: 65-byte message spans two blocks
    send_job(0, 8, 65, 0);
    finish_hash(0, 65, 8);
    chk("t2_ll0", log_b[2], 8'h41);
    chk("t2_bytes", n_core, 134);
    chk("t2_cmd01", n_cmd1, 64);

    // 3: key block + short message
    send_job(16, 16, 3, 0);
    finish_hash(16, 3, 16);
    chk("t3_kk", log_b[0], 8'h10);
    chk("t3_bytes", n_core, 134);
    chk("t3_cmd01", n_cmd1, 64);

    // 4: random stalls on both sides, single-byte hash
    send_job(8, 1, 70, 1);
    finish_hash(8, 70, 1);
    chk("t4_bytes", n_core, 6 + 192);

    // 6: bad configurations
    bad_cfg(0, 0);
    bad_cfg(33, 8);
    bad_cfg(0, 33);

    // stray hash byte mid-block
    chk_on = 1'b0;
    start_i = 1'b1; kk_i = 6'd0; nn_i = 6'd4; ll_i = LL_W'(10);
    step();
    start_i = 1'b0; msg_valid_i = 1'b1; msg_data_i = 8'h55; hash_ctrl_i = 2'b01;
    repeat (10) step();
    chk("e3_busy_before", busy_o, 1);
    hash_ctrl_i[1] = 1'b1;
    step();
    hash_ctrl_i[1] = 1'b0; msg_valid_i = 1'b0;
    @(negedge clk);
    chk("e3_err", err_o, 1);
    chk("e3_code", err_code_o, 3);
    chk("e3_idle", {busy_o, data_ctrl_o[0]}, 0);
    step();

    // 5: hash never arrives
    send_job(0, 8, 0, 0);
    chk_on = 1'b0;
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (err_o) got = 1'b1;
      else if (busy_o && !data_ctrl_o[0]) cnt++;
    end
    chk("to_seen", got, 1);
    chk("to_wait_cycles", cnt, 255);
    chk("to_code", err_code_o, 2);
    chk("to_busy", busy_o, 0);
    @(negedge clk);
    chk("to_pulse", err_o, 0);
    chk("to_code_held", err_code_o, 2);
    step();

    // reset mid-BLK
    start_i = 1'b1; kk_i = 6'd0; nn_i = 6'd8; ll_i = LL_W'(100);
    step();
    start_i = 1'b0; msg_valid_i = 1'b1; msg_data_i = 8'h77; hash_ctrl_i = 2'b01;
    repeat (15) step();
    chk("mr_busy_before", {busy_o, data_ctrl_o[0]}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy_o, 0);
    chk("mr_ctrl", {data_ctrl_o, data_o, msg_ready_o}, 0);
    chk("mr_res", {res_valid_o, res_data_o, res_last_o}, 0);
    chk("mr_flags", {done_o, err_o, err_code_o}, 0);
    msg_valid_i = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // job after reset: full key, ll on a block boundary
    send_job(32, 32, 128, 0);
    finish_hash(32, 128, 32);
    chk("pr_bytes", n_core, 6 + 192);
    chk("pr_cmd01", n_cmd1, 128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
